// File: rtl/acc_cpu_mc.sv
// acc_cpu_mc: multi-cycle accumulator CPU with a wait-state memory handshake.
// Define ACC_CPU_OVF_EN to add the signed-overflow flag output ovf.
`timescale 1ns/1ps
module acc_cpu_mc #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADR_W    = 5,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADR_W-1:0]  adr_bus,
  output logic              rd_mem,
  output logic              wr_mem,
  input  logic [DATA_W-1:0] data_bus_in,
  output logic [DATA_W-1:0] data_bus_out,
  input  logic              mem_ready,
  output logic              carry,
  output logic              zero,
  output logic              halted
`ifdef ACC_CPU_OVF_EN
  ,
  output logic              ovf
`endif
);

  localparam int unsigned OP_W = 3;
  localparam logic [OP_W-1:0] OP_LDA = 3'b000;
  localparam logic [OP_W-1:0] OP_STA = 3'b001;
  localparam logic [OP_W-1:0] OP_ADD = 3'b010;
  localparam logic [OP_W-1:0] OP_SUB = 3'b011;
  localparam logic [OP_W-1:0] OP_AND = 3'b100;
  localparam logic [OP_W-1:0] OP_JMP = 3'b101;
  localparam logic [OP_W-1:0] OP_JZ  = 3'b110;

  typedef enum logic [2:0] {
    S_START, S_FETCH, S_DECODE, S_EXEC_RD, S_EXEC_WR, S_HALT
  } state_t;

  state_t              state_q, state_d;
  logic [ADR_W-1:0]    pc_q, pc_d;
  logic [ADR_W-1:0]    ia_q, ia_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [DATA_W-1:0]   ac_q, ac_d;
  logic                c_q, c_d;
  logic [DATA_W:0]     sum, diff;
  logic [ADR_W-1:0]    adr_d;
  logic                rd_d, wr_d;
  logic [DATA_W-1:0]   dout_d;
`ifdef ACC_CPU_OVF_EN
  logic                ovf_q, ovf_d;
`endif

  // Bus outputs are registered from the next state so they stay glitch-free Moore outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_START;
      pc_q         <= ADR_W'(RESET_PC);
      ia_q         <= '0;
      op_q         <= '0;
      ac_q         <= '0;
      c_q          <= 1'b0;
      adr_bus      <= '0;
      rd_mem       <= 1'b0;
      wr_mem       <= 1'b0;
      data_bus_out <= '0;
      zero         <= 1'b1;
      halted       <= 1'b0;
`ifdef ACC_CPU_OVF_EN
      ovf_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ia_q         <= ia_d;
      op_q         <= op_d;
      ac_q         <= ac_d;
      c_q          <= c_d;
      adr_bus      <= adr_d;
      rd_mem       <= rd_d;
      wr_mem       <= wr_d;
      data_bus_out <= dout_d;
      zero         <= (ac_d == '0);
      halted       <= (state_d == S_HALT);
`ifdef ACC_CPU_OVF_EN
      ovf_q        <= ovf_d;
`endif
    end
  end

  assign carry = c_q;
`ifdef ACC_CPU_OVF_EN
  assign ovf = ovf_q;
`endif

  // Next-state, datapath update and next bus outputs.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ia_d    = ia_q;
    op_d    = op_q;
    ac_d    = ac_q;
    c_d     = c_q;
`ifdef ACC_CPU_OVF_EN
    ovf_d   = ovf_q;
`endif
    sum     = {1'b0, ac_q} + {1'b0, data_bus_in};
    diff    = {1'b0, ac_q} - {1'b0, data_bus_in};
    adr_d   = '0;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    dout_d  = '0;

    case (state_q)
      S_START: state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready) begin
          op_d    = data_bus_in[DATA_W-1 -: OP_W];
          ia_d    = data_bus_in[ADR_W-1:0];
          pc_d    = pc_q + ADR_W'(1);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (op_q)
          OP_LDA, OP_ADD, OP_SUB, OP_AND: state_d = S_EXEC_RD;
          OP_STA: state_d = S_EXEC_WR;
          OP_JMP: begin
            pc_d    = ia_q;
            state_d = S_FETCH;
          end
          OP_JZ: begin
            if (ac_q == '0) pc_d = ia_q;
            state_d = S_FETCH;
          end
          default: state_d = S_HALT;
        endcase
      end
      S_EXEC_RD: begin
        if (mem_ready) begin
          case (op_q)
            OP_ADD: begin
              {c_d, ac_d} = sum;
`ifdef ACC_CPU_OVF_EN
              ovf_d = (ac_q[DATA_W-1] == data_bus_in[DATA_W-1]) &&
                      (sum[DATA_W-1] != ac_q[DATA_W-1]);
`endif
            end
            OP_SUB: begin
              {c_d, ac_d} = diff;
`ifdef ACC_CPU_OVF_EN
              ovf_d = (ac_q[DATA_W-1] != data_bus_in[DATA_W-1]) &&
                      (diff[DATA_W-1] != ac_q[DATA_W-1]);
`endif
            end
            OP_AND:  ac_d = ac_q & data_bus_in;
            default: ac_d = data_bus_in;
          endcase
          state_d = S_FETCH;
        end
      end
      S_EXEC_WR: if (mem_ready) state_d = S_FETCH;
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_START;
    endcase

    case (state_d)
      S_FETCH: begin
        adr_d = pc_d;
        rd_d  = 1'b1;
      end
      S_EXEC_RD: begin
        adr_d = ia_d;
        rd_d  = 1'b1;
      end
      S_EXEC_WR: begin
        adr_d  = ia_d;
        wr_d   = 1'b1;
        dout_d = ac_d;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_acc_cpu_mc.sv
// Directed bench for acc_cpu_mc: small program images with hand-computed results.
`timescale 1ns/1ps
module tb_acc_cpu_mc;

  logic       tb_clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] adr_bus;
  logic       rd_mem, wr_mem;
  logic [7:0] data_bus_in, data_bus_out;
  logic       mem_ready = 1'b1;
  logic       carry, zero, halted;
`ifdef ACC_CPU_OVF_EN
  logic       ovf;
`endif

  logic [7:0] mem [32];
  logic [7:0] img [32];
  logic       load = 1'b0;
  int         wr_cnt = 0;
  int         both_cnt = 0;
  int         n_cmp = 0;
  int         n_err = 0;

  always #5 tb_clk = ~tb_clk;

  acc_cpu_mc dut (
    .clk          (tb_clk),
    .reset        (reset),
    .adr_bus      (adr_bus),
    .rd_mem       (rd_mem),
    .wr_mem       (wr_mem),
    .data_bus_in  (data_bus_in),
    .data_bus_out (data_bus_out),
    .mem_ready    (mem_ready),
    .carry        (carry),
    .zero         (zero),
    .halted       (halted)
`ifdef ACC_CPU_OVF_EN
    ,
    .ovf          (ovf)
`endif
  );

  // Shared synchronous memory: combinational read data, write on the completing edge.
  assign data_bus_in = mem[adr_bus];
  always @(posedge tb_clk) begin
    if (load) begin
      for (int i = 0; i < 32; i++) mem[i] <= img[i];
      wr_cnt <= 0;
    end else if (wr_mem && mem_ready) begin
      mem[adr_bus] <= data_bus_out;
      wr_cnt <= wr_cnt + 1;
    end
    if (rd_mem && wr_mem) both_cnt <= both_cnt + 1;
  end

  task automatic tick();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic clear_img();
    for (int i = 0; i < 32; i++) img[i] = 8'h00;
  endtask

  // Load image under reset; returns with reset released and the CPU in START.
  task automatic boot();
    reset = 1'b0;
    mem_ready = 1'b1;
    load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic run_to_halt(input string name);
    int n = 0;
    while (!halted && n < 200) begin
      tick();
      n++;
    end
    n_cmp++;
    if (halted !== 1'b1) begin
      n_err++;
      $display("FAIL %s_timeout: halted=%b after %0d cycles, want 1", name, halted, n);
    end
  endtask

  task automatic test_reset();
    clear_img();
    img[0] = 8'h14; img[20] = 8'h33;
    boot();
    tick(); tick(); tick();
    n_cmp++;
    if (rd_mem !== 1'b1 || adr_bus !== 5'd20) begin
      n_err++;
      $display("FAIL reset_pre_exec_rd: rd=%b adr=%0d, want rd=1 adr=20", rd_mem, adr_bus);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({rd_mem, wr_mem, adr_bus, data_bus_out, carry, zero, halted} !== {2'b00, 5'd0, 8'd0, 3'b010}) begin
      n_err++;
      $display("FAIL reset_async_outputs: rd=%b wr=%b adr=%0d dout=%h c=%b z=%b h=%b, want 0 0 0 00 0 1 0",
               rd_mem, wr_mem, adr_bus, data_bus_out, carry, zero, halted);
    end
    tick(); tick(); tick();
    n_cmp++;
    if ({rd_mem, wr_mem, adr_bus, data_bus_out, carry, zero, halted} !== {2'b00, 5'd0, 8'd0, 3'b010}) begin
      n_err++;
      $display("FAIL reset_held_outputs: rd=%b wr=%b adr=%0d dout=%h c=%b z=%b h=%b, want 0 0 0 00 0 1 0",
               rd_mem, wr_mem, adr_bus, data_bus_out, carry, zero, halted);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (rd_mem !== 1'b0) begin
      n_err++;
      $display("FAIL reset_start_no_read: rd=%b, want 0", rd_mem);
    end
    tick();
    // Read request is presented to the 2nd rising edge after release.
    n_cmp++;
    if (rd_mem !== 1'b1 || adr_bus !== 5'd0) begin
      n_err++;
      $display("FAIL reset_first_fetch: rd=%b adr=%0d, want rd=1 adr=0", rd_mem, adr_bus);
    end
  endtask

  task automatic test_program();
    int first = 0;
    clear_img();
    img[0] = 8'h14; img[1] = 8'h55; img[2] = 8'h36; img[3] = 8'hE0;
    img[20] = 8'h05; img[21] = 8'h07;
    boot();
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (halted === 1'b1 && first == 0) first = n;
    end
    n_cmp++;
    if (first != 12) begin
      n_err++;
      $display("FAIL prog_halt_edge: halted first at edge %0d, want 12", first);
    end
    n_cmp++;
    if (mem[22] !== 8'h0C || wr_cnt != 1) begin
      n_err++;
      $display("FAIL prog_store: M[22]=%h writes=%0d, want 0c and 1", mem[22], wr_cnt);
    end
    n_cmp++;
    if (carry !== 1'b0 || zero !== 1'b0 || rd_mem !== 1'b0 || wr_mem !== 1'b0) begin
      n_err++;
      $display("FAIL prog_final_flags: c=%b z=%b rd=%b wr=%b, want 0 0 0 0", carry, zero, rd_mem, wr_mem);
    end
  endtask

  task automatic test_alu_carry();
    clear_img();
    img[0] = 8'h10; img[1] = 8'h51; img[2] = 8'h38; img[3] = 8'h71;
    img[4] = 8'h39; img[5] = 8'h93; img[6] = 8'h3A; img[7] = 8'hE0;
    img[16] = 8'hF0; img[17] = 8'h20; img[19] = 8'h0F;
    boot();
    for (int n = 0; n < 7; n++) tick();
    n_cmp++;
    if (carry !== 1'b1 || zero !== 1'b0) begin
      n_err++;
      $display("FAIL alu_add_carry: c=%b z=%b, want 1 0", carry, zero);
    end
    run_to_halt("alu_carry");
    n_cmp++;
    if (mem[24] !== 8'h10 || mem[25] !== 8'hF0 || mem[26] !== 8'h00) begin
      n_err++;
      $display("FAIL alu_results: M24=%h M25=%h M26=%h, want 10 f0 00", mem[24], mem[25], mem[26]);
    end
    n_cmp++;
    if (carry !== 1'b1 || zero !== 1'b1) begin
      n_err++;
      $display("FAIL alu_and_keeps_carry: c=%b z=%b, want 1 1", carry, zero);
    end
  endtask

  task automatic test_sub_no_borrow();
    clear_img();
    img[0] = 8'h12; img[1] = 8'h52; img[2] = 8'h71; img[3] = 8'h38; img[4] = 8'hE0;
    img[17] = 8'h20; img[18] = 8'hFF;
    boot();
    run_to_halt("sub_nb");
    n_cmp++;
    if (mem[24] !== 8'hDE || carry !== 1'b0) begin
      n_err++;
      $display("FAIL sub_no_borrow: M24=%h c=%b, want de 0", mem[24], carry);
    end
  endtask

  task automatic test_jz(input logic [7:0] acv, input logic [4:0] want, input string name);
    clear_img();
    img[0] = 8'h10; img[1] = 8'hCA; img[2] = 8'hE0; img[10] = 8'hE0; img[16] = acv;
    boot();
    for (int n = 0; n < 6; n++) tick();
    n_cmp++;
    if (rd_mem !== 1'b1 || adr_bus !== want) begin
      n_err++;
      $display("FAIL %s: rd=%b adr=%0d, want rd=1 adr=%0d", name, rd_mem, adr_bus, want);
    end
  endtask

  task automatic test_pc_wrap();
    clear_img();
    img[0] = 8'h10; img[1] = 8'hBF; img[31] = 8'hCA; img[16] = 8'h01;
    boot();
    for (int n = 0; n < 6; n++) tick();
    n_cmp++;
    if (adr_bus !== 5'd31 || rd_mem !== 1'b1) begin
      n_err++;
      $display("FAIL jmp_target: rd=%b adr=%0d, want rd=1 adr=31", rd_mem, adr_bus);
    end
    tick(); tick();
    n_cmp++;
    if (adr_bus !== 5'd0 || rd_mem !== 1'b1) begin
      n_err++;
      $display("FAIL pc_wrap: rd=%b adr=%0d, want rd=1 adr=0", rd_mem, adr_bus);
    end
  endtask

  task automatic test_wait_states();
    int bad = 0;
    clear_img();
    img[0] = 8'h10; img[1] = 8'h34; img[2] = 8'hE0; img[16] = 8'hA5;
    boot();
    for (int n = 0; n < 4; n++) tick();
    mem_ready = 1'b0;
    for (int n = 0; n < 4; n++) begin
      tick();
      if (rd_mem !== 1'b1 || wr_mem !== 1'b0 || adr_bus !== 5'd1) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL wait_fetch_hold: %0d unstable cycles, want 0", bad);
    end
    mem_ready = 1'b1;
    tick(); tick();
    mem_ready = 1'b0;
    bad = 0;
    for (int n = 0; n < 2; n++) begin
      tick();
      if (wr_mem !== 1'b1 || rd_mem !== 1'b0 || adr_bus !== 5'd20 || data_bus_out !== 8'hA5) bad++;
    end
    n_cmp++;
    if (bad != 0 || wr_cnt != 0) begin
      n_err++;
      $display("FAIL wait_store_hold: %0d unstable cycles writes=%0d, want 0 0", bad, wr_cnt);
    end
    mem_ready = 1'b1;
    tick();
    // Zero-wait STA would finish on edge 7; six stall cycles move it to edge 13.
    n_cmp++;
    if (rd_mem !== 1'b1 || adr_bus !== 5'd2 || wr_mem !== 1'b0 || data_bus_out !== 8'h00) begin
      n_err++;
      $display("FAIL wait_end_edge: rd=%b wr=%b adr=%0d dout=%h, want 1 0 2 00", rd_mem, wr_mem, adr_bus, data_bus_out);
    end
    n_cmp++;
    if (mem[20] !== 8'hA5 || wr_cnt != 1) begin
      n_err++;
      $display("FAIL wait_store_data: M20=%h writes=%0d, want a5 1", mem[20], wr_cnt);
    end
  endtask

  task automatic test_halt_sticky();
    tick(); tick(); tick();
    mem_ready = 1'b0;
    tick(); tick();
    mem_ready = 1'b1;
    n_cmp++;
    if (halted !== 1'b1 || rd_mem !== 1'b0 || wr_mem !== 1'b0) begin
      n_err++;
      $display("FAIL halt_sticky: h=%b rd=%b wr=%b, want 1 0 0", halted, rd_mem, wr_mem);
    end
  endtask

`ifdef ACC_CPU_OVF_EN
  task automatic test_ovf();
    clear_img();
    img[0] = 8'h10; img[1] = 8'h51; img[2] = 8'h38; img[3] = 8'hE0;
    img[16] = 8'h7F; img[17] = 8'h01;
    boot();
    run_to_halt("ovf_add");
    n_cmp++;
    if (mem[24] !== 8'h80 || ovf !== 1'b1 || carry !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_add: M24=%h ovf=%b c=%b, want 80 1 0", mem[24], ovf, carry);
    end
    img[1] = 8'h71; img[16] = 8'h80;
    boot();
    #1;
    n_cmp++;
    if (ovf !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_reset: ovf=%b, want 0", ovf);
    end
    run_to_halt("ovf_sub");
    n_cmp++;
    if (mem[24] !== 8'h7F || ovf !== 1'b1 || carry !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_sub: M24=%h ovf=%b c=%b, want 7f 1 0", mem[24], ovf, carry);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_program();
    test_halt_sticky();
    test_alu_carry();
    test_sub_no_borrow();
    test_jz(8'h00, 5'd10, "jz_taken");
    test_jz(8'h01, 5'd2, "jz_not_taken");
    test_pc_wrap();
    test_wait_states();
`ifdef ACC_CPU_OVF_EN
    test_ovf();
`endif
    n_cmp++;
    if (both_cnt != 0) begin
      n_err++;
      $display("FAIL rd_wr_exclusive: %0d cycles with both high, want 0", both_cnt);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
